// File: rtl/cro_puf_pkg.sv
// Shared definitions for the configurable-ring-oscillator PUF controller.
// Contents: CRO config width, default timing parameters, FSM state encoding.
package cro_puf_pkg;

  // Config select width; tied to the CRO_block stage count.
  localparam int unsigned CFG_W = 3;

  localparam int unsigned NUM_BITS_DEFAULT   = 8;
  localparam int unsigned CNT_W_DEFAULT      = 16;
  localparam int unsigned WINDOW_CYC_DEFAULT = 1024;
  localparam int unsigned SETTLE_CYC_DEFAULT = 4;

  // Cycles with enable low after RUN so edges still in the synchroniser get counted.
  localparam int unsigned DRAIN_CYC = 3;

  typedef enum logic [2:0] {
    StIdle,
    StConfig,
    StRun,
    StDrain,
    StCompare,
    StDone
  } puf_state_e;

endpackage

// File: rtl/cro_puf_controller_edge_counter.sv
// cro_edge_counter: synchronises one asynchronous oscillator output, detects its rising
// edges and counts them in a saturating counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   osc         oscillator output, asynchronous to clk (must be slower than clk/2)
//   clr         synchronous clear of the counter (dominates cnt_en)
//   cnt_en      count detected edges while high
//   count       current edge count, saturates at all-ones
module cro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count
);

  // [0],[1]: two-flop synchroniser; [2]: previous synchronised value for edge detect.
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (cnt_en && rise && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], osc};
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cro_puf_controller.sv
// cro_puf_controller: runs NUM_BITS measurement rounds on a pair of configurable ring
// oscillators and builds a response word from the per-round edge-count comparison.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle request, accepted in IDLE only
//   challenge           round i: cfg_a = bits [6i+2:6i], cfg_b = bits [6i+5:6i+3]
//   busy                high while a challenge is being processed
//   done                1-cycle pulse; response valid from this cycle
//   response            bit i = (count A > count B) in round i
//   cro_enable          enable of both CROs, high only while measuring
//   cfg_a, cfg_b        config_sel of CRO A / CRO B
//   osc_a, osc_b        CRO outputs, asynchronous to clk
module cro_puf_controller
  import cro_puf_pkg::*;
#(
  parameter int unsigned NUM_BITS   = NUM_BITS_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned WINDOW_CYC = WINDOW_CYC_DEFAULT,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_BITS*2*CFG_W-1:0] challenge,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_BITS-1:0]       response,
  output logic                      cro_enable,
  output logic [CFG_W-1:0]          cfg_a,
  output logic [CFG_W-1:0]          cfg_b,
  input  logic                      osc_a,
  input  logic                      osc_b
);

  localparam int unsigned ChalW  = NUM_BITS * 2 * CFG_W;
  localparam int unsigned TimerW = $clog2(WINDOW_CYC + SETTLE_CYC + DRAIN_CYC) + 1;
  localparam int unsigned RoundW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  puf_state_e          state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RoundW-1:0]   round_q, round_d, next_round;
  logic [ChalW-1:0]    chal_q, chal_d;
  logic [NUM_BITS-1:0] resp_q, resp_d;
  logic [CFG_W-1:0]    cfg_a_q, cfg_a_d, cfg_b_q, cfg_b_d;
  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic                phase_last, last_round, cnt_clr, cnt_en;
  int unsigned         slice_base;

  assign next_round = round_q + RoundW'(1);
  assign last_round = (round_q == RoundW'(NUM_BITS - 1));
  assign slice_base = 32'(next_round) * 2 * CFG_W;

  // Final cycle of a timed phase; the timer restarts from 0 on every state change.
  always_comb begin
    phase_last = 1'b0;
    unique case (state_q)
      StConfig: phase_last = (timer_q == TimerW'(SETTLE_CYC - 1));
      StRun:    phase_last = (timer_q == TimerW'(WINDOW_CYC - 1));
      StDrain:  phase_last = (timer_q == TimerW'(DRAIN_CYC - 1));
      default:  phase_last = 1'b0;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      round_q <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      cfg_a_q <= '0;
      cfg_b_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      round_q <= round_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      cfg_a_q <= cfg_a_d;
      cfg_b_q <= cfg_b_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StConfig;
      StConfig:  if (phase_last) state_d = StRun;
      StRun:     if (phase_last) state_d = StDrain;
      StDrain:   if (phase_last) state_d = StCompare;
      StCompare: state_d = last_round ? StDone : StConfig;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next values: phase timer, round index, challenge/response, CRO configs.
  // Configs are loaded on entry to CONFIG so they are valid for the whole settle phase.
  always_comb begin
    timer_d = '0;
    round_d = round_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    cfg_a_d = cfg_a_q;
    cfg_b_d = cfg_b_q;
    if ((state_d == state_q) && (state_q inside {StConfig, StRun, StDrain})) begin
      timer_d = timer_q + TimerW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          chal_d  = challenge;
          round_d = '0;
          resp_d  = '0;
          cfg_a_d = challenge[CFG_W-1:0];
          cfg_b_d = challenge[2*CFG_W-1:CFG_W];
        end
      end
      StCompare: begin
        resp_d[round_q] = (cnt_a > cnt_b);
        if (!last_round) begin
          round_d = next_round;
          cfg_a_d = chal_q[slice_base +: CFG_W];
          cfg_b_d = chal_q[slice_base + CFG_W +: CFG_W];
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state so reset drops them asynchronously.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    cro_enable = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      StConfig: begin
        busy    = 1'b1;
        cnt_clr = 1'b1;
      end
      StRun: begin
        busy       = 1'b1;
        cro_enable = 1'b1;
        cnt_en     = 1'b1;
      end
      StDrain: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
      end
      StCompare: busy = 1'b1;
      StDone:    done = 1'b1;
      default: ;
    endcase
  end

  assign response = resp_q;
  assign cfg_a    = cfg_a_q;
  assign cfg_b    = cfg_b_q;

  cro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc    (osc_a),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .count  (cnt_a)
  );

  cro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc    (osc_b),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .count  (cnt_b)
  );

endmodule
